// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stages of the MIPS datapath.
//   state_t  : occupancy encoding of an elastic stage (2'd3 is illegal).
//   W_*      : standard stage-boundary field widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // no entries held
      BUSY  = 2'd1,   // main register holds one entry
      FULL  = 2'd2    // main and skid registers hold two entries
   } state_t;

   localparam int W_WORD  = 32;
   localparam int W_OP    = 6;
   localparam int W_REG   = 5;
   localparam int W_IMM15 = 15;
   localparam int W_JADDR = 26;
   localparam int W_CTRL  = 2;

endpackage

// File: rtl/pipe_stall_counter.sv
// pipe_stall_counter: 16-bit saturating event counter.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset (the only way to clear the count)
//   inc   : count one event this cycle
//   count : current count, sticks at 16'hFFFF
module pipe_stall_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 16'd0;
      end else if (inc && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: elastic pipeline stage with a valid/ready handshake.
// A main register drives the output; a skid register absorbs the one extra
// word that can arrive in the cycle downstream stalls, so in_ready depends
// only on the state register and throughput stays at one word per cycle.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   flush               : synchronous squash of all held entries
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_data             : upstream payload, WIDTH bits
//   out_valid/out_ready : downstream handshake (out_valid registered)
//   out_data            : head-of-stage payload, from the main register
//   stall_cnt           : saturating count of cycles with out_valid && !out_ready;
//                         present only when PIPE_STALL_CNT_EN is defined
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int WIDTH = W_WORD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef PIPE_STALL_CNT_EN
   output logic [15:0]      stall_cnt,
`endif
   output logic [WIDTH-1:0] out_data
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             main_from_in, main_from_skid, skid_from_in;

   // NOTE: every variable written here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt      = state;
      main_from_in   = 1'b0;
      main_from_skid = 1'b0;
      skid_from_in   = 1'b0;
      if (flush) begin
         // Data registers keep stale contents; out_valid=0 hides them.
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  main_from_in = 1'b1;
                  state_nxt    = BUSY;
               end
            end
            BUSY: begin
               case ({in_valid, out_ready})
                  2'b11: main_from_in = 1'b1;     // pass-through
                  2'b10: begin                    // downstream stalls: park in skid
                     skid_from_in = 1'b1;
                     state_nxt    = FULL;
                  end
                  2'b01: state_nxt = EMPTY;
                  default: ;
               endcase
            end
            FULL: begin
               // in_ready is low here, so in_valid cannot carry a transfer.
               if (out_ready) begin
                  main_from_skid = 1'b1;
                  state_nxt      = BUSY;
               end
            end
            default: state_nxt = EMPTY;           // illegal encoding recovers
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nxt;
         if (main_from_in) begin
            main_q <= in_data;
         end else if (main_from_skid) begin
            main_q <= skid_q;
         end
         if (skid_from_in) begin
            skid_q <= in_data;
         end
      end
   end

   // Both handshake outputs decode only the state register, so there is no
   // combinational path from out_ready or in_valid. The illegal encoding
   // reports not-ready so nothing is accepted while it recovers.
   assign out_valid = (state == BUSY) || (state == FULL);
   assign in_ready  = (state == EMPTY) || (state == BUSY);
   assign out_data  = main_q;

`ifdef PIPE_STALL_CNT_EN
   logic stall_inc;
   assign stall_inc = out_valid && !out_ready;

   pipe_stall_counter u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed self-checking bench for pipe_stage_hs.
// Inputs change and outputs are sampled on the falling edge; the DUT updates
// on the rising edge. Build with PIPE_STALL_CNT_EN to cover stall_cnt too.
module tb_pipe_stage_hs;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
   logic [15:0]      stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_stage_hs #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef PIPE_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Check the three handshake-visible outputs in one call.
   task automatic check_out(input string tag, input logic ov, input logic ir,
                            input logic [WIDTH-1:0] od);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
      check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
      check({tag, ".out_data"},  64'(out_data),  64'(od));
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // 1. Reset and idle
      repeat (2) @(negedge clk);
      check_out("reset", 1'b0, 1'b1, 32'h0);
`ifdef PIPE_STALL_CNT_EN
      check("reset.stall_cnt", 64'(stall_cnt), 64'h0);
`endif
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_out("idle", 1'b0, 1'b1, 32'h0);
      end

      // 2. Streaming 1..8, one per cycle, no bubbles
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check_out("stream", 1'b1, 1'b1, WIDTH'(i));
         if (i < 8) in_data = WIDTH'(i + 1);
         else       in_valid = 1'b0;
      end
      @(negedge clk);
      check("stream_drain.out_valid", 64'(out_valid), 64'h0);

      // 3. Back-pressure: A, B, C with downstream stalled
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
      @(negedge clk);
      check_out("bp_a", 1'b1, 1'b1, 32'hA);
      in_data = 32'hB;
      @(negedge clk);
      check_out("bp_full", 1'b1, 1'b0, 32'hA);
      in_data = 32'hC;                          // held until accepted
      @(negedge clk);
      check_out("bp_hold", 1'b1, 1'b0, 32'hA);
      out_ready = 1'b1;
      @(negedge clk);
      check_out("bp_b", 1'b1, 1'b1, 32'hB);     // C accepted at the next edge
      @(negedge clk);
      check_out("bp_c", 1'b1, 1'b1, 32'hC);
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_drain.out_valid", 64'(out_valid), 64'h0);

      // 4. Flush in FULL discards held words and the word presented with it
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
      @(negedge clk);
      in_data = 32'h22;
      @(negedge clk);
      check_out("fl_full", 1'b1, 1'b0, 32'h11);
      flush = 1'b1; in_data = 32'h33;
      @(negedge clk);
      check("flush.out_valid", 64'(out_valid), 64'h0);
      check("flush.in_ready",  64'(in_ready),  64'h1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_flush.out_valid", 64'(out_valid), 64'h0);
      end

      // 5. Asynchronous reset while BUSY
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
      @(negedge clk);
      check_out("pre_rst", 1'b1, 1'b1, 32'h55);
      in_valid = 1'b0;
      #2 rst = 1'b1;                            // between edges
      #1 check_out("async_rst", 1'b0, 1'b1, 32'h0);
`ifdef PIPE_STALL_CNT_EN
      check("async_rst.stall_cnt", 64'(stall_cnt), 64'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_out("post_rst", 1'b0, 1'b1, 32'h0);

`ifdef PIPE_STALL_CNT_EN
      // 6. Stall counter: exact count, saturation, flush keeps, reset clears
      in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("cnt_start", 64'(stall_cnt), 64'h0);
      repeat (3) @(negedge clk);
      check("cnt_three", 64'(stall_cnt), 64'h3);
      repeat (70000) @(negedge clk);
      check("cnt_sat", 64'(stall_cnt), 64'hFFFF);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("cnt_flush", 64'(stall_cnt), 64'hFFFF);
      check("cnt_flush.out_valid", 64'(out_valid), 64'h0);
      rst = 1'b1;
      #1 check("cnt_rst", 64'(stall_cnt), 64'h0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
